// File: rtl/lpc_io_router_pkg.sv
// Shared types for the LPC I/O router: FSM states, access direction and counter width.
package lpc_io_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } rt_state_e;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } rt_op_e;

  localparam int CNT_W = 8;

endpackage

// File: rtl/lpc_io_router_addr_decoder.sv
// Combinational priority address-window match: the lowest-index matching window wins.
module lpc_io_router_addr_decoder #(
  parameter int                    NUM_TGT  = 4,
  parameter logic [16*NUM_TGT-1:0] TGT_BASE = {NUM_TGT{16'h0000}},
  parameter logic [16*NUM_TGT-1:0] TGT_MASK = {NUM_TGT{16'hFFFF}}
) (
  input  logic [15:0]        addr_i,
  output logic               hit_o,
  output logic [NUM_TGT-1:0] sel_o
);

  // Walk from the top index down so the lowest matching index is the final assignment.
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if ((addr_i & TGT_MASK[16*i +: 16]) == (TGT_BASE[16*i +: 16] & TGT_MASK[16*i +: 16])) begin
        hit_o    = 1'b1;
        sel_o    = '0;
        sel_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lpc_io_router.sv
// Routes lpc_periph data-provider handshakes to address-windowed register targets
// and merges the targets' interrupts into a single irq_num/interrupt pair.
module lpc_io_router
  import lpc_io_router_pkg::*;
#(
  parameter int                    NUM_TGT  = 4,
  parameter logic [16*NUM_TGT-1:0] TGT_BASE = {NUM_TGT{16'h0000}},
  parameter logic [16*NUM_TGT-1:0] TGT_MASK = {NUM_TGT{16'hFFFF}},
  parameter int                    TIMEOUT  = 255,
  parameter logic [7:0]            DFLT_RD  = 8'hFF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [15:0]            lpc_addr_i,
  input  logic [7:0]             lpc_wdata_i,
  input  logic                   lpc_data_wr_i,
  output logic                   lpc_wr_done_o,
  input  logic                   lpc_data_req_i,
  output logic                   lpc_data_rd_o,
  output logic [7:0]             lpc_rdata_o,
  output logic [3:0]             irq_num_o,
  output logic                   interrupt_o,
  output logic [NUM_TGT-1:0]     tgt_sel_o,
  output logic                   tgt_we_o,
  output logic                   tgt_re_o,
  output logic [15:0]            tgt_addr_o,
  output logic [7:0]             tgt_wdata_o,
  input  logic [8*NUM_TGT-1:0]   tgt_rdata_i,
  input  logic [NUM_TGT-1:0]     tgt_ack_i,
  input  logic [NUM_TGT-1:0]     tgt_irq_i,
  input  logic [4*NUM_TGT-1:0]   tgt_irq_num_i,
  output logic                   timeout_o
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  rt_state_e          state_q, state_d;
  rt_op_e             op_q, op_d;
  logic               prev_wr_q, prev_req_q;
  logic [15:0]        addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [NUM_TGT-1:0] sel_q, sel_d;
  logic               we_q, we_d, re_q, re_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               done_q, done_d, rd_q, rd_d;
  logic [7:0]         rdata_q, rdata_d;
  logic [3:0]         irq_num_q, irq_num_d;
  logic               intr_q, intr_d;

  logic               wr_rise, req_rise, host_sig;
  logic               dec_hit;
  logic [NUM_TGT-1:0] dec_sel;
  logic               ack_hit;
  logic [7:0]         sel_rdata;

  lpc_io_router_addr_decoder #(
    .NUM_TGT  (NUM_TGT),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK)
  ) u_dec (
    .addr_i (addr_q),
    .hit_o  (dec_hit),
    .sel_o  (dec_sel)
  );

  assign wr_rise  = lpc_data_wr_i & ~prev_wr_q;
  assign req_rise = lpc_data_req_i & ~prev_req_q;
  assign host_sig = (op_q == OP_RD) ? lpc_data_req_i : lpc_data_wr_i;

  // Only the currently selected target's ack and data are honoured.
  always_comb begin
    ack_hit   = |(tgt_ack_i & sel_q);
    sel_rdata = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (sel_q[i]) sel_rdata = tgt_rdata_i[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    done_d    = done_q;
    rd_d      = rd_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_rise || req_rise) begin
          op_d    = wr_rise ? OP_WR : OP_RD;
          addr_d  = lpc_addr_i;
          wdata_d = lpc_wdata_i;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_hit) begin
          sel_d   = dec_sel;
          we_d    = (op_q == OP_WR);
          re_d    = (op_q == OP_RD);
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end else begin
          if (op_q == OP_RD) rdata_d = DFLT_RD;
          state_d = ST_HOLD;
        end
      end
      ST_ACCESS: begin
        // An ack on the final counted cycle wins over the timeout.
        if (ack_hit || (cnt_q == TO_CNT)) begin
          if (ack_hit) begin
            if (op_q == OP_RD) rdata_d = sel_rdata;
          end else begin
            timeout_d = 1'b1;
            rdata_d   = DFLT_RD;
          end
          sel_d = '0;
          if (host_sig) begin
            done_d  = (op_q == OP_WR);
            rd_d    = (op_q == OP_RD);
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (host_sig) begin
          done_d = (op_q == OP_WR);
          rd_d   = (op_q == OP_RD);
        end else begin
          done_d  = 1'b0;
          rd_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // irq_num keeps its last value while no target is requesting.
  always_comb begin
    intr_d    = |tgt_irq_i;
    irq_num_d = irq_num_q;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (tgt_irq_i[i]) irq_num_d = tgt_irq_num_i[4*i +: 4];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_WR;
      prev_wr_q  <= 1'b0;
      prev_req_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
      rd_q       <= 1'b0;
      rdata_q    <= '0;
      irq_num_q  <= '0;
      intr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      prev_wr_q  <= lpc_data_wr_i;
      prev_req_q <= lpc_data_req_i;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      re_q       <= re_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      irq_num_q  <= irq_num_d;
      intr_q     <= intr_d;
    end
  end

  assign lpc_wr_done_o = done_q;
  assign lpc_data_rd_o = rd_q;
  assign lpc_rdata_o   = rdata_q;
  assign irq_num_o     = irq_num_q;
  assign interrupt_o   = intr_q;
  assign tgt_sel_o     = sel_q;
  assign tgt_we_o      = we_q;
  assign tgt_re_o      = re_q;
  assign tgt_addr_o    = addr_q;
  assign tgt_wdata_o   = wdata_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_lpc_io_router.sv
// Self-checking bench for lpc_io_router: host driver, simple target responder, response scoreboard.
module tb_lpc_io_router;

  localparam int N = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [15:0]      lpc_addr_i;
  logic [7:0]       lpc_wdata_i;
  logic             lpc_data_wr_i;
  logic             lpc_wr_done_o;
  logic             lpc_data_req_i;
  logic             lpc_data_rd_o;
  logic [7:0]       lpc_rdata_o;
  logic [3:0]       irq_num_o;
  logic             interrupt_o;
  logic [N-1:0]     tgt_sel_o;
  logic             tgt_we_o;
  logic             tgt_re_o;
  logic [15:0]      tgt_addr_o;
  logic [7:0]       tgt_wdata_o;
  logic [8*N-1:0]   tgt_rdata_i;
  logic [N-1:0]     tgt_ack_i;
  logic [N-1:0]     tgt_irq_i;
  logic [4*N-1:0]   tgt_irq_num_i;
  logic             timeout_o;

  // Windows: T0 0x0080/FFF0, T1 0x0060/FFF8, T2 0x0FF0/FFF0, T3 0x0000/FF00 (overlaps T0, T1).
  lpc_io_router #(
    .NUM_TGT  (N),
    .TGT_BASE ({16'h0000, 16'h0FF0, 16'h0060, 16'h0080}),
    .TGT_MASK ({16'hFF00, 16'hFFF0, 16'hFFF8, 16'hFFF0}),
    .TIMEOUT  (255),
    .DFLT_RD  (8'hFF)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .lpc_addr_i     (lpc_addr_i),
    .lpc_wdata_i    (lpc_wdata_i),
    .lpc_data_wr_i  (lpc_data_wr_i),
    .lpc_wr_done_o  (lpc_wr_done_o),
    .lpc_data_req_i (lpc_data_req_i),
    .lpc_data_rd_o  (lpc_data_rd_o),
    .lpc_rdata_o    (lpc_rdata_o),
    .irq_num_o      (irq_num_o),
    .interrupt_o    (interrupt_o),
    .tgt_sel_o      (tgt_sel_o),
    .tgt_we_o       (tgt_we_o),
    .tgt_re_o       (tgt_re_o),
    .tgt_addr_o     (tgt_addr_o),
    .tgt_wdata_o    (tgt_wdata_o),
    .tgt_rdata_i    (tgt_rdata_i),
    .tgt_ack_i      (tgt_ack_i),
    .tgt_irq_i      (tgt_irq_i),
    .tgt_irq_num_i  (tgt_irq_num_i),
    .timeout_o      (timeout_o)
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected end within 500us");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  logic [8:0] exp_q[$];   // {is_rd, data}
  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int n_strobe = 0, strobe_cyc = 0, n_resp = 0, resp_cyc = 0, n_to = 0;
  logic [N-1:0] strobe_sel = '0;
  logic strobe_we = 1'b0;
  logic prev_done = 1'b0, prev_rd = 1'b0;

  // Target responder configuration for the access in flight
  int cur_tgt = 0, cur_delay = 0, ack_cnt = 0;
  logic [7:0] cur_rdata = '0;
  bit ack_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample just after the edge, then run the target model and the monitor.
  task automatic step();
    logic [8:0] e;
    @(posedge clk_i);
    #1;
    cyc++;
    tgt_ack_i = '0;
    if (ack_pending) begin
      ack_cnt++;
      if (cur_delay >= 0 && ack_cnt == cur_delay) begin
        tgt_rdata_i = $urandom;
        tgt_rdata_i[8*cur_tgt +: 8] = cur_rdata;
        tgt_ack_i[cur_tgt] = 1'b1;
        ack_pending = 1'b0;
      end else if (cur_delay < 0 && ack_cnt == 5) begin
        tgt_ack_i[(cur_tgt + 1) % N] = 1'b1;   // stray ack from an unselected target
      end else if (ack_cnt > 300) begin
        ack_pending = 1'b0;
      end
    end
    if (tgt_we_o || tgt_re_o) begin
      n_strobe++;
      strobe_cyc  = cyc;
      strobe_sel  = tgt_sel_o;
      strobe_we   = tgt_we_o;
      ack_pending = 1'b1;
      ack_cnt     = 0;
    end
    if (timeout_o) n_to++;
    if ((lpc_data_rd_o && !prev_rd) || (lpc_wr_done_o && !prev_done)) begin
      n_resp++;
      resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_is_rd", {31'd0, lpc_data_rd_o}, {31'd0, e[8]});
        check("resp_data", e[8] ? {24'd0, lpc_rdata_o} : {24'd0, tgt_wdata_o}, {24'd0, e[7:0]});
      end
    end
    prev_rd   = lpc_data_rd_o;
    prev_done = lpc_wr_done_o;
  endtask

  // Full host access. tgt < 0 means no window claims it; d < 0 means the target never acks.
  task automatic run_access(input string tag, input bit is_rd, input logic [15:0] addr,
                            input logic [7:0] wdata, input int tgt, input int d,
                            input logic [7:0] trd, input logic [7:0] exp_rd);
    int c0, s0, r0, t0, budget, exp_lat;
    cur_tgt = (tgt < 0) ? 0 : tgt;
    cur_delay = d;
    cur_rdata = trd;
    s0 = n_strobe; r0 = n_resp; t0 = n_to;
    if (is_rd) exp_q.push_back({1'b1, exp_rd});
    else       exp_q.push_back({1'b0, wdata});
    lpc_addr_i  = addr;
    lpc_wdata_i = wdata;
    if (is_rd) lpc_data_req_i = 1'b1;
    else       lpc_data_wr_i  = 1'b1;
    c0 = cyc;
    budget = 0;
    while (n_resp == r0 && budget < 400) begin
      step();
      budget++;
    end
    if (n_resp == r0) check({tag, "_no_resp"}, 32'd0, 32'd1);
    exp_lat = (tgt < 0) ? 3 : ((d < 0) ? 258 : 3 + d);
    check({tag, "_latency"}, resp_cyc - c0, exp_lat);
    check({tag, "_strobes"}, n_strobe - s0, (tgt < 0) ? 0 : 1);
    check({tag, "_timeouts"}, n_to - t0, (tgt >= 0 && d < 0) ? 1 : 0);
    check({tag, "_addr"}, {16'd0, tgt_addr_o}, {16'd0, addr});
    check({tag, "_sel_idle"}, {28'd0, tgt_sel_o}, 32'd0);
    if (tgt >= 0) begin
      check({tag, "_strobe_sel"}, {28'd0, strobe_sel}, 32'd1 << tgt);
      check({tag, "_strobe_at"}, strobe_cyc - c0, 32'd2);
      check({tag, "_strobe_we"}, {31'd0, strobe_we}, {31'd0, ~is_rd});
    end
    step();
    step();
    check({tag, "_held"}, {31'd0, is_rd ? lpc_data_rd_o : lpc_wr_done_o}, 32'd1);
    lpc_data_req_i = 1'b0;
    lpc_data_wr_i  = 1'b0;
    step();
    check({tag, "_released"}, {31'd0, is_rd ? lpc_data_rd_o : lpc_wr_done_o}, 32'd0);
    step();
  endtask

  int r0, s0, budget;
  logic [7:0] rv;

  initial begin
    rst_i = 1'b1;
    lpc_addr_i = '0; lpc_wdata_i = '0; lpc_data_wr_i = 1'b0; lpc_data_req_i = 1'b0;
    tgt_rdata_i = '0; tgt_ack_i = '0; tgt_irq_i = '0; tgt_irq_num_i = '0;
    repeat (3) step();
    check("rst_outputs", {lpc_wr_done_o, lpc_data_rd_o, interrupt_o, tgt_we_o, tgt_re_o, timeout_o},
          32'd0);
    check("rst_data", {lpc_rdata_o, irq_num_o, tgt_sel_o, tgt_wdata_o}, 32'd0);
    check("rst_addr", {16'd0, tgt_addr_o}, 32'd0);
    rst_i = 1'b0;
    step();

    // Write hit on T0, read hits on T2, misses
    run_access("wr_t0", 1'b0, 16'h0080, 8'h5A, 0, 2, 8'h00, 8'h00);
    run_access("rd_t2", 1'b1, 16'h0FF4, 8'h00, 2, 1, 8'hC3, 8'hC3);
    run_access("rd_miss", 1'b1, 16'h1234, 8'h00, -1, 1, 8'h00, 8'hFF);
    run_access("wr_miss", 1'b0, 16'h1234, 8'hA7, -1, 1, 8'h00, 8'h00);
    run_access("rd_t3_pri", 1'b1, 16'h0010, 8'h00, 3, 3, 8'h3C, 8'h3C);

    // Timeout with a stray ack, then an ack on the very last counted cycle
    run_access("rd_timeout", 1'b1, 16'h0020, 8'h00, 3, -1, 8'h00, 8'hFF);
    run_access("rd_ack255", 1'b1, 16'h0020, 8'h00, 3, 255, 8'h99, 8'h99);

    // Host abandons a read while the target is busy
    cur_tgt = 2; cur_delay = 3; cur_rdata = 8'h11;
    r0 = n_resp; s0 = n_strobe;
    lpc_addr_i = 16'h0FF8;
    lpc_data_req_i = 1'b1;
    step();
    step();
    lpc_data_req_i = 1'b0;
    repeat (10) step();
    check("abort_no_rd", n_resp - r0, 32'd0);
    check("abort_strobes", n_strobe - s0, 32'd1);
    check("abort_rd_low", {31'd0, lpc_data_rd_o}, 32'd0);
    run_access("rd_after_abort", 1'b1, 16'h0FF1, 8'h00, 2, 1, 8'h6D, 8'h6D);

    // Randomised accesses on T1 / T2
    for (int k = 0; k < 6; k++) begin
      rv = 8'($urandom_range(0, 255));
      if (k % 2 == 0)
        run_access("rand_rd", 1'b1, 16'h0FF0 + 16'($urandom_range(0, 15)), 8'h00, 2,
                   $urandom_range(1, 6), rv, rv);
      else
        run_access("rand_wr", 1'b0, 16'h0060 + 16'($urandom_range(0, 7)), rv, 1,
                   $urandom_range(1, 6), 8'h00, 8'h00);
    end

    // Interrupt merge: irq nums {t3,t2,t1,t0} = {A,7,3,B}
    tgt_irq_num_i = {4'hA, 4'h7, 4'h3, 4'hB};
    tgt_irq_i = 4'b0110;
    check("irq_latency", {31'd0, interrupt_o}, 32'd0);
    step();
    check("irq_int", {31'd0, interrupt_o}, 32'd1);
    check("irq_num", {28'd0, irq_num_o}, 32'd3);
    tgt_irq_i = 4'b0100;
    step();
    check("irq_num_t2", {28'd0, irq_num_o}, 32'd7);
    tgt_irq_i = 4'b0000;
    step();
    check("irq_clear_int", {31'd0, interrupt_o}, 32'd0);
    check("irq_num_hold", {28'd0, irq_num_o}, 32'd7);
    tgt_irq_i = 4'b1010;
    step();
    check("irq_num_t1", {28'd0, irq_num_o}, 32'd3);
    tgt_irq_i = 4'b0000;
    step();
    check("irq_num_hold2", {28'd0, irq_num_o}, 32'd3);

    // Reset while the router is holding a read response
    tgt_irq_i = 4'b1111;
    cur_tgt = 2; cur_delay = 1; cur_rdata = 8'h42;
    exp_q.push_back({1'b1, 8'h42});
    r0 = n_resp;
    lpc_addr_i = 16'h0FF2;
    lpc_data_req_i = 1'b1;
    budget = 0;
    while (n_resp == r0 && budget < 50) begin
      step();
      budget++;
    end
    check("rsthold_rd_seen", n_resp - r0, 32'd1);
    rst_i = 1'b1;
    lpc_data_req_i = 1'b0;
    step();
    check("rsthold_rd", {31'd0, lpc_data_rd_o}, 32'd0);
    check("rsthold_sel", {28'd0, tgt_sel_o}, 32'd0);
    check("rsthold_irq", {27'd0, interrupt_o, irq_num_o}, 32'd0);
    rst_i = 1'b0;
    tgt_irq_i = 4'b0000;
    step();
    step();
    run_access("rd_after_rst", 1'b1, 16'h0FF3, 8'h00, 2, 2, 8'h5E, 8'h5E);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
